// File: rtl/fifo_pkg.sv
// Pointer/depth helpers shared by the single-clock FIFO and its future dual-clock variant.
package fifo_pkg;

    // Widest pointer the helpers accept; callers zero-extend their pointers to this width.
    localparam int PTR_MAX = 32;

    function automatic int ptr_width(input int w);
        return w + 1;
    endfunction

    function automatic int fifo_depth(input int w);
        return 1 << w;
    endfunction

    // Address bits equal and wrap bits differ: the writer is exactly one lap ahead.
    function automatic logic ptr_full(input logic [PTR_MAX-1:0] wr_ptr,
                                      input logic [PTR_MAX-1:0] rd_ptr,
                                      input int w);
        return (wr_ptr ^ rd_ptr) == (PTR_MAX'(1) << w);
    endfunction

    function automatic logic ptr_empty(input logic [PTR_MAX-1:0] wr_ptr,
                                       input logic [PTR_MAX-1:0] rd_ptr);
        return wr_ptr == rd_ptr;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Purpose: B x 2**W register array, one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port after the writing edge; read is combinational.
// Backpressure: none; the caller guarantees write addresses are legal.
module fifo_ram #(
    parameter int B = 8,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         we,
    input  logic [W-1:0] waddr,
    input  logic [B-1:0] wdata,
    input  logic [W-1:0] raddr,
    output logic [B-1:0] rdata
);

    logic [B-1:0] mem [2**W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Purpose: single-clock FIFO with occupancy count, almost flags and overflow/underflow pulses; FIFO_FWFT_EN selects first-word-fall-through reads.
// Latency: flags/count update the cycle after the accepting edge; r_data 1 cycle after read (FWFT: head shown combinationally).
// Backpressure: writes to a full FIFO are dropped (overflow pulse) unless a read frees a slot that cycle; reads when empty are ignored (underflow pulse).
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int B     = 8,
    parameter int W     = 4,
    parameter int AF_TH = 12,
    parameter int AE_TH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rd,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    output logic [B-1:0] r_data,
    output logic         empty,
    output logic         full,
    output logic         almost_empty,
    output logic         almost_full,
    output logic [W:0]   count,
    output logic         overflow,
    output logic         underflow
);

    localparam int DEPTH = fifo_depth(W);
    localparam int PW    = ptr_width(W);

    if (W < 1 || AF_TH < 1 || AF_TH > DEPTH || AE_TH < 0 || AE_TH > DEPTH - 1) begin : g_param_check
        $error("sync_fifo_flags: illegal W/AF_TH/AE_TH combination");
    end

    localparam logic [W:0] AF_CNT = (W + 1)'(AF_TH);
    localparam logic [W:0] AE_CNT = (W + 1)'(AE_TH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          rd_acc;
    logic          wr_acc;
    logic          overflow_q;
    logic          underflow_q;
    logic [B-1:0]  ram_rdata;

    assign empty = ptr_empty(PTR_MAX'(wr_ptr), PTR_MAX'(rd_ptr));
    assign full  = ptr_full(PTR_MAX'(wr_ptr), PTR_MAX'(rd_ptr), W);

    // Pointer difference is always 0..DEPTH thanks to the wrap bit.
    assign count        = wr_ptr - rd_ptr;
    assign almost_full  = count >= AF_CNT;
    assign almost_empty = count <= AE_CNT;

    assign rd_acc = rd && !empty;
    assign wr_acc = wr && (!full || rd_acc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            overflow_q  <= wr && !wr_acc;
            underflow_q <= rd && !rd_acc;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    fifo_ram #(
        .B (B),
        .W (W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[W-1:0]),
        .wdata (w_data),
        .raddr (rd_ptr[W-1:0]),
        .rdata (ram_rdata)
    );

`ifdef FIFO_FWFT_EN
    assign r_data = ram_rdata;
`else
    logic [B-1:0] r_data_q;

    // On simultaneous read/write at full the old head is captured before the write lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_q <= '0;
        end else if (rd_acc) begin
            r_data_q <= ram_rdata;
        end
    end

    assign r_data = r_data_q;
`endif

endmodule
